// File: rtl/bob_retire_ctl.sv
// Retire-side controller for the branch order buffer: tracks resolve status per entry,
// retires resolved heads in order and converts a mispredicted head into a flush pulse.
module bob_retire_ctl #(
    parameter int ADDR_WIDTH   = 6,
    parameter int ADDR_COUNT   = 48,
    parameter int DATA_WIDTH   = 72,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  new_en,
    input  logic [ADDR_WIDTH-1:0] new_addr,
    input  logic                  res_en,
    input  logic [ADDR_WIDTH-1:0] res_addr,
    input  logic                  res_mispred,
    input  logic                  ext_except,
    input  logic                  hasRetire,
    input  logic [ADDR_WIDTH-1:0] retire_addr,
    output logic                  ram_read_clkEn,
    output logic [ADDR_WIDTH-1:0] ram_read_addr,
    input  logic [DATA_WIDTH-1:0] ram_read_data,
    output logic                  doRetire,
    output logic                  except,
    output logic [63:0]           except_target,
    output logic                  ret_en,
    output logic [DATA_WIDTH-1:0] ret_data
);

    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] head_q;
    logic [ADDR_COUNT-1:0] done;
    logic [ADDR_COUNT-1:0] mis;
    logic [CNT_W-1:0]      flush_cnt;
    logic [DATA_WIDTH-1:0] ret_data_q;
    logic [63:0]           target_q;
    logic                  rdy;
    logic                  head_mis;

    // The RAM is addressed with the next head so its data lines up with head_q.
    assign ram_read_clkEn = ~rst;
    assign ram_read_addr  = retire_addr;

    always_comb begin
        rdy      = ~rst & (state == RUN) & hasRetire & done[head_q] & ~ext_except;
        head_mis = mis[head_q];
    end

    assign doRetire      = rdy & ~head_mis;
    assign except        = rdy & head_mis;
    assign ret_en        = rdy;
    assign ret_data      = rdy ? ram_read_data : ret_data_q;
    assign except_target = except ? ram_read_data[63:0] : target_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            done       <= '0;
            mis        <= '0;
            flush_cnt  <= '0;
            head_q     <= '0;
            ret_data_q <= '0;
            target_q   <= '0;
        end else begin
            head_q     <= retire_addr;
            ret_data_q <= ret_data;
            target_q   <= except_target;
            // An external flush takes priority over a mispredict seen in the same cycle.
            if (ext_except || except) begin
                done      <= '0;
                mis       <= '0;
                state     <= FLUSH;
                flush_cnt <= FLUSH_LOAD;
            end else begin
                if (new_en) begin
                    done[new_addr] <= 1'b0;
                    mis[new_addr]  <= 1'b0;
                end
                if (res_en) begin
                    done[res_addr] <= 1'b1;
                    mis[res_addr]  <= res_mispred;
                end
                if (state == FLUSH) begin
                    if (flush_cnt <= CNT_W'(1)) begin
                        state     <= RUN;
                        flush_cnt <= '0;
                    end else begin
                        flush_cnt <= flush_cnt - CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bob_retire_ctl.sv
// Directed bench for bob_retire_ctl with a small bob_addr/bob_ram stand-in around it.
module tb_bob_retire_ctl;

    localparam int AW = 6;
    localparam int DW = 72;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          new_en = 1'b0;
    logic [AW-1:0] new_addr = '0;
    logic          res_en = 1'b0;
    logic [AW-1:0] res_addr = '0;
    logic          res_mispred = 1'b0;
    logic          ext_except = 1'b0;
    logic          hasRetire;
    logic [AW-1:0] retire_addr;
    logic          ram_read_clkEn;
    logic [AW-1:0] ram_read_addr;
    logic [DW-1:0] ram_read_data;
    logic          doRetire;
    logic          except;
    logic [63:0]   except_target;
    logic          ret_en;
    logic [DW-1:0] ret_data;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] head_m = '0;
    int            cnt_m = 0;
    logic [DW-1:0] mem [0:63];
    logic [DW-1:0] ram_q = '0;

    always #5 clk = ~clk;

    bob_retire_ctl #(
        .ADDR_WIDTH(AW), .ADDR_COUNT(48), .DATA_WIDTH(DW), .FLUSH_CYCLES(2)
    ) dut (
        .clk(clk), .rst(rst),
        .new_en(new_en), .new_addr(new_addr),
        .res_en(res_en), .res_addr(res_addr), .res_mispred(res_mispred),
        .ext_except(ext_except),
        .hasRetire(hasRetire), .retire_addr(retire_addr),
        .ram_read_clkEn(ram_read_clkEn), .ram_read_addr(ram_read_addr),
        .ram_read_data(ram_read_data),
        .doRetire(doRetire), .except(except), .except_target(except_target),
        .ret_en(ret_en), .ret_data(ret_data)
    );

    function automatic logic [DW-1:0] val(input int i);
        return {8'hA0 + 8'(i), 64'(i) << 12};
    endfunction

    // bob_addr stand-in: head advances on retire and steps past a mispredicted branch.
    assign hasRetire     = (cnt_m != 0);
    assign retire_addr   = doRetire ? ((head_m == 6'd47) ? 6'd0 : head_m + 6'd1) : head_m;
    assign ram_read_data = ram_q;

    always @(posedge clk) begin
        if (rst) begin
            head_m <= '0;
            cnt_m  <= 0;
        end else if (except) begin
            head_m <= (head_m == 6'd47) ? 6'd0 : head_m + 6'd1;
            cnt_m  <= 0;
        end else begin
            head_m <= retire_addr;
            cnt_m  <= cnt_m + (new_en ? 1 : 0) - (doRetire ? 1 : 0);
        end
        if (ram_read_clkEn) ram_q <= mem[ram_read_addr];
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs and check {doRetire, except, ret_en} before the next edge.
    task automatic step(input string tag, input logic n_en, input logic [AW-1:0] n_a,
                        input logic r_en, input logic [AW-1:0] r_a, input logic r_m,
                        input logic x, input logic [2:0] e_out);
        @(negedge clk);
        rst = 1'b0;
        new_en = n_en; new_addr = n_a;
        res_en = r_en; res_addr = r_a; res_mispred = r_m;
        ext_except = x;
        #2;
        chk(tag, DW'({doRetire, except, ret_en}), DW'(e_out));
    endtask

    task automatic rst_cycle(input string tag);
        @(negedge clk);
        rst = 1'b1;
        new_en = 1'b0; res_en = 1'b0; res_mispred = 1'b0; ext_except = 1'b0;
        #2;
        chk(tag, DW'({doRetire, except, ret_en, ram_read_clkEn}), DW'(0));
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = val(i);

        @(negedge clk);
        @(negedge clk);
        #2;
        chk("rst_ctrl", DW'({doRetire, except, ret_en, ram_read_clkEn}), DW'(0));
        chk("rst_ret_data", ret_data, DW'(0));
        chk("rst_target", DW'(except_target), DW'(0));

        // In-order retire with out-of-order resolve
        step("t1_a0", 1, 0, 0, 0, 0, 0, 3'b000);
        step("t1_a1", 1, 1, 0, 0, 0, 0, 3'b000);
        step("t1_a2", 1, 2, 0, 0, 0, 0, 3'b000);
        step("t1_a3", 1, 3, 0, 0, 0, 0, 3'b000);
        step("t1_r2", 0, 0, 1, 2, 0, 0, 3'b000);
        step("t1_r0", 0, 0, 1, 0, 0, 0, 3'b000);
        step("t1_r3", 0, 0, 1, 3, 0, 0, 3'b101);
        chk("t1_d0", ret_data, val(0));
        step("t1_r1", 0, 0, 1, 1, 0, 0, 3'b000);
        step("t1_ret1", 0, 0, 0, 0, 0, 0, 3'b101);
        chk("t1_d1", ret_data, val(1));
        step("t1_ret2", 0, 0, 0, 0, 0, 0, 3'b101);
        chk("t1_d2", ret_data, val(2));
        step("t1_ret3", 0, 0, 0, 0, 0, 0, 3'b101);
        chk("t1_d3", ret_data, val(3));
        step("t1_idle", 0, 0, 0, 0, 0, 0, 3'b000);
        chk("t1_hold", ret_data, val(3));

        // Mispredicted head: except pulse, then two blocked cycles
        rst_cycle("t2_rst0");
        rst_cycle("t2_rst1");
        step("t2_a0", 1, 0, 0, 0, 0, 0, 3'b000);
        step("t2_a1", 1, 1, 0, 0, 0, 0, 3'b000);
        step("t2_a2", 1, 2, 0, 0, 0, 0, 3'b000);
        step("t2_r1m", 0, 0, 1, 1, 1, 0, 3'b000);
        step("t2_r0", 0, 0, 1, 0, 0, 0, 3'b000);
        step("t2_ret0", 0, 0, 0, 0, 0, 0, 3'b101);
        chk("t2_d0", ret_data, val(0));
        step("t2_except", 0, 0, 0, 0, 0, 0, 3'b011);
        chk("t2_target", DW'(except_target), DW'(64'h1000));
        chk("t2_mis_data", ret_data, val(1));
        step("t2_flush1", 1, 2, 1, 2, 0, 0, 3'b000);
        chk("t2_target_hold", DW'(except_target), DW'(64'h1000));
        step("t2_flush2", 0, 0, 0, 0, 0, 0, 3'b000);
        step("t2_ret2", 0, 0, 0, 0, 0, 0, 3'b101);
        chk("t2_d2", ret_data, val(2));
        step("t2_idle", 0, 0, 0, 0, 0, 0, 3'b000);

        // Fill all 48 entries and wrap the head 47 -> 0
        rst_cycle("t3_rst0");
        rst_cycle("t3_rst1");
        for (int i = 0; i < 48; i++) begin
            step("t3_fill", 1, AW'(i), 1, AW'(i), 0, 0, (i == 0) ? 3'b000 : 3'b101);
            if (i > 0) chk("t3_data", ret_data, val(i - 1));
        end
        step("t3_ret47", 0, 0, 0, 0, 0, 0, 3'b101);
        chk("t3_d47", ret_data, val(47));
        chk("t3_wrap_addr", DW'(ram_read_addr), DW'(0));
        step("t3_empty", 0, 0, 0, 0, 0, 0, 3'b000);
        step("t3_a0", 1, 0, 1, 0, 0, 0, 3'b000);
        step("t3_a1", 1, 1, 1, 1, 0, 0, 3'b101);
        chk("t3_wrap_d0", ret_data, val(0));
        step("t3_ret1", 0, 0, 0, 0, 0, 0, 3'b101);
        chk("t3_wrap_d1", ret_data, val(1));
        step("t3_idle", 0, 0, 0, 0, 0, 0, 3'b000);

        // External flush beats a mispredicted head and clears the scoreboard
        rst_cycle("t5_rst0");
        rst_cycle("t5_rst1");
        step("t5_a0", 1, 0, 0, 0, 0, 0, 3'b000);
        step("t5_r0m", 0, 0, 1, 0, 1, 0, 3'b000);
        step("t5_ext", 0, 0, 0, 0, 0, 1, 3'b000);
        chk("t5_target", DW'(except_target), DW'(0));
        step("t5_flush1", 0, 0, 0, 0, 0, 0, 3'b000);
        step("t5_flush2", 0, 0, 0, 0, 0, 0, 3'b000);
        step("t5_cleared", 0, 0, 0, 0, 0, 0, 3'b000);
        step("t5_r0", 0, 0, 1, 0, 0, 0, 3'b000);
        step("t5_ret0", 0, 0, 0, 0, 0, 0, 3'b101);
        chk("t5_d0", ret_data, val(0));

        // Reset in the middle of a flush window
        step("t6_a1r1m", 1, 1, 1, 1, 1, 0, 3'b000);
        step("t6_except", 0, 0, 0, 0, 0, 0, 3'b011);
        chk("t6_target", DW'(except_target), DW'(64'h1000));
        rst_cycle("t6_rst");
        step("t6_after", 1, 0, 1, 0, 0, 0, 3'b000);
        chk("t6_ret_data", ret_data, DW'(0));
        chk("t6_target0", DW'(except_target), DW'(0));
        chk("t6_clken", DW'(ram_read_clkEn), DW'(1));
        step("t6_run", 0, 0, 0, 0, 0, 0, 3'b101);
        chk("t6_d0", ret_data, val(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
